// File: rtl/iob_wstrb_splitter.sv
// ---------------------------------------------------------------------------
// iob_wstrb_splitter
//
// Takes one native write (word address, data, byte strobes) and replays it as
// a sequence of byte-addressed beats, one per contiguous run of set strobe
// bits, lowest lane first. Each beat carries the byte address of its first
// lane, the data realigned so that byte sits on lane 0 (unused upper lanes
// zero) and the number of bytes in the beat. A request with no strobes set
// still produces a single zero-byte beat so that every request terminates
// with m_last_o.
//
// Ports:
//   clk_i        clock
//   arst_n_i     asynchronous reset, active-low
//   cke_i        clock enable; when low every register holds
//   s_valid_i    request valid
//   s_addr_i     request byte address (low $clog2(N) bits ignored)
//   s_wdata_i    request write data
//   s_wstrb_i    request byte strobes
//   s_ready_o    request accepted when high together with s_valid_i
//   m_valid_o    beat valid
//   m_addr_o     beat byte address
//   m_wdata_o    beat data, first byte on lane 0, upper lanes zero
//   m_nbytes_o   bytes in the beat, 0..N
//   m_last_o     final beat of the request
//   m_ready_i    downstream accepts the beat
//
// Build option:
//   IOB_WSTRB_SPLITTER_POW2_EN  when defined, every beat is naturally aligned
//   and power-of-two sized; longer or misaligned runs are broken into several
//   beats. When undefined a beat covers a whole run of any length.
// ---------------------------------------------------------------------------
module iob_wstrb_splitter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic                            cke_i,
    input  logic                            s_valid_i,
    input  logic [ADDR_W-1:0]               s_addr_i,
    input  logic [DATA_W-1:0]               s_wdata_i,
    input  logic [DATA_W/8-1:0]             s_wstrb_i,
    output logic                            s_ready_o,
    output logic                            m_valid_o,
    output logic [ADDR_W-1:0]               m_addr_o,
    output logic [DATA_W-1:0]               m_wdata_o,
    output logic [$clog2(DATA_W/8):0]       m_nbytes_o,
    output logic                            m_last_o,
    input  logic                            m_ready_i
);

    localparam int N     = DATA_W / 8;
    localparam int OFF_W = $clog2(N);
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [N-1:0]      strb_q,  strb_d;

    logic [OFF_W-1:0]  off;
    logic [N-1:0]      strb_shift;
    logic              run_open;
    logic [CNT_W-1:0]  run;
    logic [CNT_W-1:0]  size;
    logic [N-1:0]      beat_mask;
    logic [N-1:0]      strb_rest;
    logic [DATA_W-1:0] data_shift;
    logic [DATA_W-1:0] beat_data;
    logic              beat_last;
    logic              in_send;

    // The low address bits are replaced by the beat offset, so they are never read.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^s_addr_i[OFF_W-1:0];

    // ------------------------------------------------------------------
    // Beat extraction from the residual strobes
    // ------------------------------------------------------------------

    // Lowest set residual bit wins; scanning downward lets the lowest overwrite.
    always_comb begin
        off = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (strb_q[i-1]) begin
                off = OFF_W'(i - 1);
            end
        end
    end

    // Length of the run of ones starting at off.
    always_comb begin
        strb_shift = strb_q >> off;
        run        = '0;
        run_open   = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (run_open && strb_shift[i]) begin
                run = run + CNT_W'(1);
            end else begin
                run_open = 1'b0;
            end
        end
    end

`ifdef IOB_WSTRB_SPLITTER_POW2_EN
    // Largest 2^k that fits in the run and divides off; both conditions only
    // get harder as k grows, so the last hit in the ascending scan is the answer.
    always_comb begin
        size = '0;
        for (int unsigned k = 0; k <= OFF_W; k++) begin
            if (((CNT_W'(1) << k) <= run) &&
                ((off & OFF_W'((1 << k) - 1)) == '0)) begin
                size = CNT_W'(1) << k;
            end
        end
    end
`else
    always_comb begin
        size = run;
    end
`endif

    // Lanes consumed by this beat: [off, off+size). off+size never exceeds N.
    always_comb begin
        beat_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            beat_mask[i] = (CNT_W'(i) >= CNT_W'(off)) &&
                           (CNT_W'(i) <  (CNT_W'(off) + size));
        end
    end

    always_comb begin
        strb_rest = strb_q & ~beat_mask;
        beat_last = (strb_rest == '0);
    end

    // Realign to lane 0 and blank lanes beyond the beat size.
    always_comb begin
        data_shift = data_q >> {off, 3'b000};
        beat_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (CNT_W'(i) < size) begin
                beat_data[8*i +: 8] = data_shift[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: forced to zero outside SEND so IDLE looks like reset
    // ------------------------------------------------------------------
    assign in_send    = (state_q == SEND);
    assign s_ready_o  = (state_q == IDLE);
    assign m_valid_o  = in_send;
    assign m_addr_o   = in_send ? (addr_q | ADDR_W'(off)) : '0;
    assign m_wdata_o  = in_send ? beat_data : '0;
    assign m_nbytes_o = in_send ? size : '0;
    assign m_last_o   = in_send & beat_last;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        if (cke_i) begin
            unique case (state_q)
                IDLE: begin
                    if (s_valid_i) begin
                        addr_d  = {s_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        data_d  = s_wdata_i;
                        strb_d  = s_wstrb_i;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (m_ready_i) begin
                        strb_d = strb_rest;
                        if (beat_last) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

endmodule

// File: tb/tb_iob_wstrb_splitter.sv
// ---------------------------------------------------------------------------
// tb_iob_wstrb_splitter
//
// Bench for iob_wstrb_splitter with DATA_W=32. Requests are expanded by a
// behavioural model into the expected beat list, queued, and compared by a
// monitor against every valid beat; entries are retired on handshake.
// ---------------------------------------------------------------------------
module tb_iob_wstrb_splitter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int N      = DATA_W / 8;
    localparam int CNT_W  = $clog2(N) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  nbytes;
        logic              last;
    } beat_t;

    logic              clk_i = 1'b0;
    logic              arst_n_i;
    logic              cke_i;
    logic              s_valid_i;
    logic [ADDR_W-1:0] s_addr_i;
    logic [DATA_W-1:0] s_wdata_i;
    logic [N-1:0]      s_wstrb_i;
    logic              s_ready_o;
    logic              m_valid_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [CNT_W-1:0]  m_nbytes_o;
    logic              m_last_o;
    logic              m_ready_i;

    beat_t       exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          rand_rdy = 1'b0;

    iob_wstrb_splitter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .s_valid_i  (s_valid_i),
        .s_addr_i   (s_addr_i),
        .s_wdata_i  (s_wdata_i),
        .s_wstrb_i  (s_wstrb_i),
        .s_ready_o  (s_ready_o),
        .m_valid_o  (m_valid_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_nbytes_o (m_nbytes_o),
        .m_last_o   (m_last_o),
        .m_ready_i  (m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference expansion of one request into beats.
    task automatic push_model(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                              input logic [N-1:0] strb);
        beat_t             tmp[$];
        beat_t             b;
        int                i, j, len, pos, sz;
        logic [ADDR_W-1:0] word;
        logic [DATA_W-1:0] mask;
        word = addr & ~ADDR_W'(N - 1);
        if (strb == '0) begin
            b.addr = word; b.data = '0; b.nbytes = '0; b.last = 1'b0;
            tmp.push_back(b);
        end
        i = 0;
        while (i < N) begin
            if (!strb[i]) begin
                i++;
            end else begin
                j = i;
                while (j < N && strb[j]) j++;
                len = j - i;
                pos = i;
                while (len > 0) begin
`ifdef IOB_WSTRB_SPLITTER_POW2_EN
                    sz = 1;
                    while ((sz * 2 <= len) && ((pos % (sz * 2)) == 0)) sz = sz * 2;
`else
                    sz = len;
`endif
                    mask = (sz >= N) ? '1 : ((DATA_W'(1) << (8 * sz)) - DATA_W'(1));
                    b.addr   = word + ADDR_W'(pos);
                    b.data   = (data >> (8 * pos)) & mask;
                    b.nbytes = CNT_W'(sz);
                    b.last   = 1'b0;
                    tmp.push_back(b);
                    pos += sz;
                    len -= sz;
                end
                i = j;
            end
        end
        tmp[tmp.size() - 1].last = 1'b1;
        foreach (tmp[k]) exp_q.push_back(tmp[k]);
    endtask

    // Every valid beat must equal the head of the queue; retire on handshake.
    always @(negedge clk_i) begin
        if (arst_n_i === 1'b1 && m_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'd1, 64'd0);
            end else begin
                chk("m_addr",   m_addr_o,   exp_q[0].addr);
                chk("m_wdata",  m_wdata_o,  exp_q[0].data);
                chk("m_nbytes", m_nbytes_o, exp_q[0].nbytes);
                chk("m_last",   m_last_o,   exp_q[0].last);
                if (m_ready_i && cke_i) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk_i) begin
        if (rand_rdy) begin
            #1;
            m_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Waits for IDLE, presents the request for exactly one accepting edge.
    task automatic send_req(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [N-1:0] strb);
        int guard = 0;
        while (s_ready_o !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("s_ready_timeout", s_ready_o, 1);
        s_valid_i = 1'b1;
        s_addr_i  = addr;
        s_wdata_i = data;
        s_wstrb_i = strb;
        push_model(addr, data, strb);
        tick();
        s_valid_i = 1'b0;
        s_addr_i  = $urandom;
        s_wdata_i = $urandom;
        s_wstrb_i = N'($urandom);
        chk("accept_m_valid", m_valid_o, 1);
        chk("accept_s_ready", s_ready_o, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        arst_n_i  = 1'b0;
        cke_i     = 1'b1;
        s_valid_i = 1'b0;
        s_addr_i  = '0;
        s_wdata_i = '0;
        s_wstrb_i = '0;
        m_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_s_ready",  s_ready_o,  1);
        chk("rst_m_valid",  m_valid_o,  0);
        chk("rst_m_last",   m_last_o,   0);
        chk("rst_m_addr",   m_addr_o,   0);
        chk("rst_m_wdata",  m_wdata_o,  0);
        chk("rst_m_nbytes", m_nbytes_o, 0);
        arst_n_i = 1'b1;
        tick();

        // Full word: one beat, visible the cycle after accept, ready returns after handshake.
        send_req(32'h100, 32'hDDCC_BBAA, 4'b1111);
        chk("full_addr",   m_addr_o,   32'h100);
        chk("full_wdata",  m_wdata_o,  32'hDDCC_BBAA);
        chk("full_nbytes", m_nbytes_o, 4);
        chk("full_last",   m_last_o,   1);
        tick();
        chk("full_s_ready_back", s_ready_o, 1);
        chk("full_m_valid_off",  m_valid_o, 0);

        send_req(32'h104, 32'h4433_2211, 4'b0101);
        chk("sparse_b1_addr",  m_addr_o,  32'h104);
        chk("sparse_b1_wdata", m_wdata_o, 32'h11);
        chk("sparse_b1_last",  m_last_o,  0);
        drain();

        send_req(32'h20, 32'hDDCC_BBAA, 4'b1110);
`ifdef IOB_WSTRB_SPLITTER_POW2_EN
        chk("run3_addr",   m_addr_o,   32'h21);
        chk("run3_nbytes", m_nbytes_o, 1);
        chk("run3_wdata",  m_wdata_o,  32'h0000_00BB);
        chk("run3_last",   m_last_o,   0);
`else
        chk("run3_addr",   m_addr_o,   32'h21);
        chk("run3_nbytes", m_nbytes_o, 3);
        chk("run3_wdata",  m_wdata_o,  32'h00DD_CCBB);
        chk("run3_last",   m_last_o,   1);
`endif
        drain();

        send_req(32'h40, 32'hFFFF_FFFF, 4'b0000);
        chk("zero_addr",   m_addr_o,   32'h40);
        chk("zero_nbytes", m_nbytes_o, 0);
        chk("zero_wdata",  m_wdata_o,  0);
        chk("zero_last",   m_last_o,   1);
        drain();

        send_req(32'h107, 32'h8877_6655, 4'b1001);
        drain();
        send_req(32'h20B, 32'hCAFE_F00D, 4'b0110);
        drain();
        send_req(32'h300, 32'h1234_5678, 4'b0111);
        drain();

        // Backpressure: beat 1 held for three cycles.
        m_ready_i = 1'b0;
        send_req(32'h104, 32'h4433_2211, 4'b0101);
        for (int c = 0; c < 3; c++) begin
            chk("bp_m_valid", m_valid_o, 1);
            chk("bp_s_ready", s_ready_o, 0);
            chk("bp_m_addr",  m_addr_o,  32'h104);
            tick();
        end
        m_ready_i = 1'b1;
        drain();

        // Clock enable low in SEND: no handshake completes.
        m_ready_i = 1'b0;
        send_req(32'h104, 32'h4433_2211, 4'b0101);
        cke_i     = 1'b0;
        m_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("cke_m_valid", m_valid_o, 1);
            chk("cke_m_addr",  m_addr_o,  32'h104);
        end
        cke_i = 1'b1;
        drain();

        // Reset during beat 1: request dropped, beat 2 never appears.
        m_ready_i = 1'b0;
        send_req(32'h104, 32'h4433_2211, 4'b0101);
        #1;
        arst_n_i = 1'b0;
        #1;
        chk("mid_rst_m_valid",  m_valid_o,  0);
        chk("mid_rst_s_ready",  s_ready_o,  1);
        chk("mid_rst_m_addr",   m_addr_o,   0);
        chk("mid_rst_m_wdata",  m_wdata_o,  0);
        chk("mid_rst_m_nbytes", m_nbytes_o, 0);
        chk("mid_rst_m_last",   m_last_o,   0);
        exp_q.delete();
        arst_n_i  = 1'b1;
        m_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_m_valid", m_valid_o, 0);
            chk("post_rst_s_ready", s_ready_o, 1);
        end

        // Random traffic with random downstream stalls.
        rand_rdy = 1'b1;
        for (int r = 0; r < 40; r++) begin
            send_req($urandom, $urandom, N'($urandom_range(0, 15)));
        end
        drain();
        rand_rdy = 1'b0;
        tick();
        m_ready_i = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iob_wstrb_splitter.md
Name: iob_wstrb_splitter

Overview:
- Sequential stage that takes one native write (word address, data, byte strobes) and emits it as a series of byte-addressed beats, one per contiguous run of set strobe bits.
- Each beat carries a byte address, lane-0-aligned data and a byte count.
- Sits downstream of the strobe-to-byte-offset encoder and reuses its lowest-set-bit priority rule.
- Feeds narrow or byte-addressed targets: UART/SPI FIFOs and AXI-Lite bridges.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8; N = DATA_W/8 byte lanes, N a power of two >= 2
- ADDR_W, 32, byte address width; must exceed $clog2(N)

Ports:
- clk_i  input  1  clock
- arst_n_i  input  1  asynchronous reset, active-low
- cke_i  input  1  clock enable; when low, all state holds
- s_valid_i  input  1  upstream request valid
- s_addr_i  input  ADDR_W  request byte address; low $clog2(N) bits ignored
- s_wdata_i  input  DATA_W  write data
- s_wstrb_i  input  N  byte strobes
- s_ready_o  output  1  request accepted when high with s_valid_i
- m_valid_o  output  1  beat valid
- m_addr_o  output  ADDR_W  beat byte address
- m_wdata_o  output  DATA_W  beat data, first byte on lane 0, upper lanes zero
- m_nbytes_o  output  $clog2(N)+1  bytes in beat, 0..N
- m_last_o  output  1  final beat of the request
- m_ready_i  input  1  downstream accepts the beat

Behaviour:
- Reset (arst_n_i low, asynchronous) state:
  - state IDLE; s_ready_o=1; m_valid_o=0; m_last_o=0.
  - m_addr_o, m_wdata_o and m_nbytes_o are 0.
  - Captured address, data and residual strobe registers cleared.
- States: IDLE and SEND. All transitions require cke_i=1.
- IDLE:
  - s_ready_o=1 and m_valid_o=0.
  - On s_valid_i, capture the word address (s_addr_i with low bits zeroed), s_wdata_i, and s_wstrb_i into the residual register; go to SEND.
  - First beat is valid on the next cycle (1-cycle latency).
- SEND:
  - s_ready_o=0 and m_valid_o=1.
  - Beat fields are combinational from the registers:
    - off = index of the lowest set residual bit (0 if none).
    - run = count of consecutive set bits starting at off.
    - m_addr_o = word address | off.
    - m_wdata_o = data >> (8*off), with lanes at index >= run forced to 0.
    - m_nbytes_o = run.
    - m_last_o = 1 when the residual with those run bits cleared is zero.
  - On m_valid_o && m_ready_i, clear the run bits from the residual. If m_last_o, go to IDLE; otherwise stay in SEND with the next run.
- Backpressure: while m_ready_i=0, all m_* outputs hold stable.
- Zero strobe: an accepted request with s_wstrb_i=0 produces exactly one beat: m_nbytes_o=0, m_addr_o=word address, m_wdata_o=0, m_last_o=1.
- Number of beats per request = number of contiguous strobe runs, at most N/2 (min 1).
- No request overlap: a new request is accepted only in IDLE, at the earliest the cycle after the last beat completes. No combinational path from m_ready_i to s_ready_o.
- Reset mid-SEND: the in-flight request is dropped, no further beats are issued, and the block returns to IDLE.
- cke_i low in SEND: outputs and registers frozen; a handshake does not complete.

Optional Feature:
- Macro IOB_WSTRB_SPLITTER_POW2_EN.
- Defined: each beat is naturally aligned and power-of-two sized. run is replaced by the largest 2^k <= run such that off is a multiple of 2^k. The remaining bits of the run are emitted in subsequent beats. m_last_o and residual clearing use this reduced size.
- Undefined: beats cover whole contiguous runs of any length 1..N.

Test Plan:
- DATA_W=32, addr 0x100, wstrb 1111, data 0xDDCCBBAA -> one beat: addr 0x100, wdata 0xDDCCBBAA, nbytes 4, last 1. Beat appears the cycle after accept; s_ready_o is high again the cycle after the handshake.
- addr 0x104, wstrb 0101, data 0x44332211:
  - beat 1: addr 0x104, wdata 0x00000011, nbytes 1, last 0
  - beat 2: addr 0x106, wdata 0x00000033, nbytes 1, last 1
- addr 0x20, wstrb 1110, data 0xDDCCBBAA:
  - without POW2: one beat: addr 0x21, wdata 0x00DDCCBB, nbytes 3, last 1
  - with IOB_WSTRB_SPLITTER_POW2_EN: beat 1 addr 0x21, nbytes 1, wdata 0x000000BB; beat 2 addr 0x22, nbytes 2, wdata 0x0000DDCC, last 1
- wstrb 0101, m_ready_i held low 3 cycles on beat 1 -> m_* stable for 3 cycles, s_ready_o=0 throughout, then both beats issue in order.
- wstrb 0000, addr 0x40 -> single beat: addr 0x40, nbytes 0, wdata 0, last 1.
- arst_n_i pulsed low during beat 1 of wstrb 0101 -> m_valid_o=0 immediately, s_ready_o=1, all outputs 0, and beat 2 is never emitted.
